// File: rtl/udp_builder.sv
// UDP header builder: prepends an 8-byte UDP header to a 64-bit payload stream.
// Optional payload length checking is enabled by defining UDP_LEN_CHECK_EN.
module udp_builder (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] data_slave,
   input  logic [7:0]  keep_slave,
   input  logic        valid_slave,
   input  logic        last_slave,
   output logic        ready_slave,
   output logic [63:0] data_master,
   output logic [7:0]  keep_master,
   output logic        valid_master,
   output logic        last_master,
   input  logic        ready_master,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [15:0] local_udp_port,
   input  logic [15:0] udp_dst_port_in,
   input  logic [15:0] payload_length_in,
   output logic [15:0] udp_length,
   output logic        busy,
   output logic        length_error
);

   localparam logic [2:0] S_IDLE = 3'b001;
   localparam logic [2:0] S_HEAD = 3'b010;
   localparam logic [2:0] S_DATA = 3'b100;

   logic [2:0]  state_q, state_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] udp_len_q, udp_len_d;
   logic [15:0] plen_q, plen_d;

   logic        start_fire;
   logic        beat_fire;
   logic        last_fire;
   logic [63:0] header_word;

   assign start_fire = (state_q == S_IDLE) && start_valid;
   assign beat_fire  = (state_q == S_DATA) && valid_slave && ready_master;
   assign last_fire  = beat_fire && last_slave;

   // Each 16-bit field goes out big-endian: its high byte sits in the lower byte lane.
   assign header_word = {16'h0000,
                         udp_len_q[7:0], udp_len_q[15:8],
                         dst_q[7:0],     dst_q[15:8],
                         src_q[7:0],     src_q[15:8]};

   assign udp_length = udp_len_q;
   assign busy       = (state_q != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         udp_len_q <= '0;
         plen_q    <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         udp_len_q <= udp_len_d;
         plen_q    <= plen_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      udp_len_d = udp_len_q;
      plen_d    = plen_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               src_d     = local_udp_port;
               dst_d     = udp_dst_port_in;
               udp_len_d = payload_length_in + 16'd8;
               plen_d    = payload_length_in;
               state_d   = S_HEAD;
            end
         end
         S_HEAD: begin
            if (ready_master) begin
               state_d = (plen_q == 16'd0) ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (last_fire) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_ready  = 1'b0;
      ready_slave  = 1'b0;
      data_master  = '0;
      keep_master  = '0;
      valid_master = 1'b0;
      last_master  = 1'b0;
      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
         end
         S_HEAD: begin
            data_master  = header_word;
            keep_master  = 8'hFF;
            valid_master = 1'b1;
            last_master  = (plen_q == 16'd0);
         end
         S_DATA: begin
            data_master  = data_slave;
            keep_master  = keep_slave;
            valid_master = valid_slave;
            last_master  = last_slave;
            ready_slave  = ready_master;
         end
         default: begin
            start_ready = 1'b0;
         end
      endcase
   end

`ifdef UDP_LEN_CHECK_EN
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [3:0]  beat_bytes;
   logic [15:0] cnt_with_beat;

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < 8; i++) begin
         beat_bytes = beat_bytes + {3'b000, keep_slave[i]};
      end
   end

   assign cnt_with_beat = cnt_q + {12'h000, beat_bytes};

   always_comb begin
      cnt_d = cnt_q;
      err_d = 1'b0;
      if (start_fire) begin
         cnt_d = '0;
      end else if (beat_fire) begin
         cnt_d = cnt_with_beat;
         err_d = last_slave && (cnt_with_beat != plen_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign length_error = err_q;
`else
   assign length_error = 1'b0;
`endif

endmodule

// File: tb/tb_udp_builder.sv
// Directed self-checking bench for udp_builder; expected beats are hand-computed.
module tb_udp_builder;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] data_slave;
   logic [7:0]  keep_slave;
   logic        valid_slave;
   logic        last_slave;
   logic        ready_slave;
   logic [63:0] data_master;
   logic [7:0]  keep_master;
   logic        valid_master;
   logic        last_master;
   logic        ready_master;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] local_udp_port;
   logic [15:0] udp_dst_port_in;
   logic [15:0] payload_length_in;
   logic [15:0] udp_length;
   logic        busy;
   logic        length_error;

   int total = 0;
   int bad   = 0;

   udp_builder dut (
      .clk               (clk),
      .rst               (rst),
      .data_slave        (data_slave),
      .keep_slave        (keep_slave),
      .valid_slave       (valid_slave),
      .last_slave        (last_slave),
      .ready_slave       (ready_slave),
      .data_master       (data_master),
      .keep_master       (keep_master),
      .valid_master      (valid_master),
      .last_master       (last_master),
      .ready_master      (ready_master),
      .start_valid       (start_valid),
      .start_ready       (start_ready),
      .local_udp_port    (local_udp_port),
      .udp_dst_port_in   (udp_dst_port_in),
      .payload_length_in (payload_length_in),
      .udp_length        (udp_length),
      .busy              (busy),
      .length_error      (length_error)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic start_req(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
      local_udp_port    = src;
      udp_dst_port_in   = dst;
      payload_length_in = len;
      start_valid       = 1'b1;
      settle();
      total++;
      if (start_ready !== 1'b1) begin
         bad++;
         $display("FAIL start_rdy_idle: got %b want 1", start_ready);
      end
      tick();
      start_valid = 1'b0;
      settle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      settle();
      total++;
      if ({valid_master, last_master, ready_slave, busy, length_error, start_ready} !== 6'b000001) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 000001",
                  {valid_master, last_master, ready_slave, busy, length_error, start_ready});
      end
      total++;
      if ({udp_length, keep_master, data_master} !== 88'h0) begin
         bad++;
         $display("FAIL reset_data: got udp_len=%h keep=%h data=%h want all 0", udp_length, keep_master, data_master);
      end
      tick();
      rst = 1'b0;
      settle();
      $display("reset: checked");
   endtask

   task automatic test_basic();
      start_req(16'h1234, 16'h5678, 16'd16);
      total++;
      if ({valid_master, last_master, keep_master, ready_slave} !== 11'b1_0_11111111_0 ||
          data_master !== 64'h0000_1800_7856_3412) begin
         bad++;
         $display("FAIL basic_header: got v=%b l=%b k=%h rs=%b d=%h want v=1 l=0 k=ff rs=0 d=0000180078563412",
                  valid_master, last_master, keep_master, ready_slave, data_master);
      end
      total++;
      if (udp_length !== 16'h0018 || busy !== 1'b1 || start_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_len: got udp_len=%h busy=%b sr=%b want 0018 1 0", udp_length, busy, start_ready);
      end
      ready_master = 1'b1;
      tick();
      $display("basic: header beat %h", 64'h0000_1800_7856_3412);
      valid_slave = 1'b1; data_slave = 64'h1111_2222_3333_4444; keep_slave = 8'hFF; last_slave = 1'b0;
      settle();
      total++;
      if (data_master !== 64'h1111_2222_3333_4444 || valid_master !== 1'b1 || last_master !== 1'b0 ||
          ready_slave !== 1'b1 || keep_master !== 8'hFF) begin
         bad++;
         $display("FAIL basic_beat1: got d=%h v=%b l=%b rs=%b k=%h", data_master, valid_master, last_master, ready_slave, keep_master);
      end
      tick();
      data_slave = 64'h5555_6666_7777_8888; last_slave = 1'b1;
      settle();
      total++;
      if (data_master !== 64'h5555_6666_7777_8888 || last_master !== 1'b1 || valid_master !== 1'b1) begin
         bad++;
         $display("FAIL basic_beat2: got d=%h l=%b v=%b want 5555666677778888 1 1", data_master, last_master, valid_master);
      end
      tick();
      valid_slave = 1'b0; last_slave = 1'b0;
      settle();
      total++;
      if (start_ready !== 1'b1 || valid_master !== 1'b0 || busy !== 1'b0 || length_error !== 1'b0) begin
         bad++;
         $display("FAIL basic_end: got sr=%b v=%b busy=%b err=%b want 1 0 0 0", start_ready, valid_master, busy, length_error);
      end
      $display("basic: two payload beats forwarded");
   endtask

   task automatic test_zero_len();
      ready_master = 1'b1;
      valid_slave  = 1'b1; data_slave = 64'hDEAD_BEEF_0000_0001; keep_slave = 8'hFF; last_slave = 1'b1;
      start_req(16'h0001, 16'h0002, 16'd0);
      total++;
      if (valid_master !== 1'b1 || last_master !== 1'b1 || udp_length !== 16'h0008 || ready_slave !== 1'b0 ||
          data_master !== 64'h0000_0800_0200_0100) begin
         bad++;
         $display("FAIL zero_header: got v=%b l=%b udp=%h rs=%b d=%h want 1 1 0008 0 0000080002000100",
                  valid_master, last_master, udp_length, ready_slave, data_master);
      end
      tick();
      total++;
      if (start_ready !== 1'b1 || busy !== 1'b0 || valid_master !== 1'b0 || ready_slave !== 1'b0) begin
         bad++;
         $display("FAIL zero_idle: got sr=%b busy=%b v=%b rs=%b want 1 0 0 0", start_ready, busy, valid_master, ready_slave);
      end
      valid_slave = 1'b0; last_slave = 1'b0;
      $display("zero_len: single header beat");
   endtask

   task automatic test_backpressure();
      ready_master = 1'b0;
      start_req(16'hA0B0, 16'hC0D0, 16'd16);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (data_master !== 64'h0000_1800_D0C0_B0A0 || valid_master !== 1'b1 || ready_slave !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_head_hold%0d: got d=%h v=%b rs=%b busy=%b", i, data_master, valid_master, ready_slave, busy);
         end
         tick();
      end
      ready_master = 1'b1;
      tick();
      valid_slave = 1'b1; data_slave = 64'h0102_0304_0506_0708; keep_slave = 8'hFF; last_slave = 1'b0;
      tick();
      data_slave = 64'h090A_0B0C_0D0E_0F10; last_slave = 1'b1; ready_master = 1'b0;
      settle();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ready_slave !== 1'b0 || data_master !== 64'h090A_0B0C_0D0E_0F10 || busy !== 1'b1 || last_master !== 1'b1) begin
            bad++;
            $display("FAIL bp_data_hold%0d: got rs=%b d=%h busy=%b l=%b", i, ready_slave, data_master, busy, last_master);
         end
         tick();
      end
      ready_master = 1'b1;
      settle();
      total++;
      if (ready_slave !== 1'b1 || valid_master !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: got rs=%b v=%b want 1 1", ready_slave, valid_master);
      end
      tick();
      valid_slave = 1'b0; last_slave = 1'b0;
      settle();
      total++;
      if (start_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_end: got sr=%b busy=%b want 1 0", start_ready, busy);
      end
      $display("backpressure: header and payload held across stalls");
   endtask

   task automatic run_len(input logic [15:0] len, input logic exp_err, input string tag);
      ready_master = 1'b1;
      start_req(16'h0BAD, 16'h0F00, len);
      tick();
      valid_slave = 1'b1; data_slave = 64'hAAAA_BBBB_CCCC_DDDD; keep_slave = 8'hFF; last_slave = 1'b0;
      tick();
      data_slave = 64'h0000_0000_1234_5678; keep_slave = 8'h0F; last_slave = 1'b1;
      settle();
      total++;
      if (keep_master !== 8'h0F || last_master !== 1'b1 || length_error !== 1'b0) begin
         bad++;
         $display("FAIL %s_last: got k=%h l=%b err=%b want 0f 1 0", tag, keep_master, last_master, length_error);
      end
      tick();
      valid_slave = 1'b0; last_slave = 1'b0; keep_slave = 8'h00;
      settle();
      total++;
      if (length_error !== exp_err || start_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_err: got err=%b sr=%b want err=%b sr=1", tag, length_error, start_ready, exp_err);
      end
      tick();
      total++;
      if (length_error !== 1'b0) begin
         bad++;
         $display("FAIL %s_err_pulse: got err=%b want 0", tag, length_error);
      end
      $display("len_check %s: len=%0d err_expected=%b", tag, len, exp_err);
   endtask

   task automatic test_len_check();
      logic exp13;
`ifdef UDP_LEN_CHECK_EN
      exp13 = 1'b1;
`else
      exp13 = 1'b0;
`endif
      run_len(16'd12, 1'b0, "len12");
      run_len(16'd13, exp13, "len13");
   endtask

   task automatic test_reset_mid();
      ready_master = 1'b1;
      start_req(16'h1111, 16'h2222, 16'd24);
      tick();
      valid_slave = 1'b1; data_slave = 64'h7777_7777_7777_7777; keep_slave = 8'hFF; last_slave = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      total++;
      if (start_ready !== 1'b1 || valid_master !== 1'b0 || busy !== 1'b0 || ready_slave !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_idle: got sr=%b v=%b busy=%b rs=%b want 1 0 0 0", start_ready, valid_master, busy, ready_slave);
      end
      rst = 1'b0; valid_slave = 1'b0;
      settle();
      start_req(16'hABCD, 16'h0102, 16'd8);
      total++;
      if (data_master !== 64'h0000_1000_0201_CDAB || udp_length !== 16'h0010 || last_master !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_header: got d=%h udp=%h l=%b want 0000100002 01cdab 0010 0", data_master, udp_length, last_master);
      end
      tick();
      valid_slave = 1'b1; data_slave = 64'h0123_4567_89AB_CDEF; keep_slave = 8'hFF; last_slave = 1'b1;
      settle();
      total++;
      if (data_master !== 64'h0123_4567_89AB_CDEF || last_master !== 1'b1 || ready_slave !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_beat: got d=%h l=%b rs=%b", data_master, last_master, ready_slave);
      end
      tick();
      valid_slave = 1'b0; last_slave = 1'b0;
      settle();
      total++;
      if (start_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_end: got sr=%b busy=%b want 1 0", start_ready, busy);
      end
      $display("reset_mid: truncated datagram dropped, next datagram built");
   endtask

   initial begin
      rst = 1'b1;
      data_slave = '0; keep_slave = '0; valid_slave = 1'b0; last_slave = 1'b0;
      ready_master = 1'b0; start_valid = 1'b0;
      local_udp_port = '0; udp_dst_port_in = '0; payload_length_in = '0;
      #2;
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_len_check();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
